x_pwm_8_bit: RTL and testbench
==============================

Name: x_pwm_8_bit

Overview:
- Downstream consumer of the free-running 8-bit counter. It takes the eight individual count bits and generates a glitch-free PWM output by comparing the count against a duty value.
- A new duty value is double-buffered: it is loaded into a shadow register and committed only at counter wrap (0xFF->0x00).
- The block also flags a wrap pulse each period and latches a sticky error if the count stream is not a clean +1 sequence.

Parameters:
- RESET_DUTY, 8'd0, active and shadow duty value after reset.
- CHECK_SEQ, 1, 1 enables the sequence checker (o_seq_err); 0 ties o_seq_err low.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_count_7 .. i_count_0  input  1 each  count bits from the upstream counter, MSB to LSB; count = {i_count_7..i_count_0}.
- i_duty_7 .. i_duty_0  input  1 each  new duty value, sampled when i_load=1.
- i_load  input  1  load strobe; writes the duty into the shadow register.
- o_pwm  output  1  PWM output, registered.
- o_wrap  output  1  one-cycle pulse, registered, on detected wrap.
- o_pending  output  1  shadow holds an uncommitted duty.
- o_seq_err  output  1  sticky sequence-error flag.

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high. No other clock or async path.
- Reset (i_rst=1 at an edge):
  - active_q = shadow_q = RESET_DUTY.
  - pend_q = 0, o_pwm = 0, o_wrap = 0, o_seq_err = 0.
  - prev_valid_q = 0, prev_q = 0.
- prev_q holds the count from the previous cycle. prev_valid_q is set 1 on the first non-reset edge.
- wrap (combinational) = prev_valid_q & (prev_q == 8'hFF) & (count == 8'h00).
- Shadow load:
  - i_load=1 -> shadow_q <= duty, pend_q <= 1.
  - A load while pend_q=1 overwrites the shadow; last write wins.
- Commit:
  - eff_duty = (wrap & pend_q) ? shadow_q : active_q.
  - On wrap & pend_q: active_q <= shadow_q, pend_q <= 0.
- Same-cycle i_load and wrap:
  - The commit uses the old shadow_q.
  - The new duty goes into the shadow, and pend_q ends at 1.
  - The new value is committed at the next wrap.
- PWM:
  - o_pwm <= (count < eff_duty), unsigned 8-bit compare. Latency is 1 cycle from count to o_pwm.
  - Duty 0 -> o_pwm constantly 0.
  - Duty 255 -> high for counts 0..254, low for 255.
  - There is no 100% duty; this is by design.
- o_wrap <= wrap. Exactly one pulse per 256 cycles for a clean counter.
- o_pending = pend_q.
- Sequence checker (CHECK_SEQ=1):
  - If prev_valid_q and count != prev_q + 1 (mod 256), then o_seq_err <= 1.
  - The flag clears only on i_rst.
  - A non-wrapping jump (e.g. 0x10->0x20) produces no o_wrap and no commit.
- Upstream counter held in reset (count stuck at 0x00):
  - No wrap, so pending duty stays pending.
  - o_pwm = (0 < active_q).
  - o_seq_err sets if prev_valid_q.
- Reset mid-period:
  - All state returns to reset values on the next edge, including any pending duty, which is discarded.
  - The sequence checker ignores the first post-reset sample.

Test Plan:
- Reset then clean count 0x00->0xFF->0x00, RESET_DUTY=0 -> o_pwm=0 throughout; o_wrap high exactly one cycle after count=0x00 is presented; o_seq_err=0.
- Load duty=0x40 at count=0x80 -> o_pending=1 until the wrap; after the wrap, o_pwm high for counts 0x00..0x3F (64 cycles, delayed 1), low for 192 cycles; o_pending=0.
- Load 0x10 then 0x C0 before the wrap -> active becomes 0xC0 (192 high cycles); 0x10 never appears.
- i_load with duty=0xFF in the same cycle as the wrap, with the old pending value 0x20 -> the period uses 0x20 and o_pending stays 1; the next period gives 255 high and 1 low.
- Count jumps 0x10->0x20 -> o_seq_err=1 from the next cycle and stays 1 through later clean wraps; cleared only by i_rst=1.
- Assert i_rst for 1 cycle mid-period with a load pending -> the next cycle has o_pwm=0, o_pending=0, active=RESET_DUTY; no o_seq_err on the first sample after reset.

Source files
------------

// File: rtl/x_pwm_8_bit.sv
// x_pwm_8_bit: PWM generator driven by an external 8-bit counter.
// Double-buffered duty committed at wrap, plus a wrap pulse and a sequence checker.
module x_pwm_8_bit #(
  parameter logic [7:0] RESET_DUTY = 8'd0,
  parameter bit         CHECK_SEQ  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_count_7,
  input  logic i_count_6,
  input  logic i_count_5,
  input  logic i_count_4,
  input  logic i_count_3,
  input  logic i_count_2,
  input  logic i_count_1,
  input  logic i_count_0,
  input  logic i_duty_7,
  input  logic i_duty_6,
  input  logic i_duty_5,
  input  logic i_duty_4,
  input  logic i_duty_3,
  input  logic i_duty_2,
  input  logic i_duty_1,
  input  logic i_duty_0,
  input  logic i_load,
  output logic o_pwm,
  output logic o_wrap,
  output logic o_pending,
  output logic o_seq_err
);

  logic [7:0] w_count;
  logic [7:0] w_duty;
  logic [7:0] w_prev_inc;
  logic [7:0] w_eff_duty;
  logic       w_wrap;
  logic       w_commit;
  logic       w_seq_bad;

  logic [7:0] r_active;
  logic [7:0] r_shadow;
  logic [7:0] r_prev;
  logic       r_prev_valid;
  logic       r_pend;
  logic       r_pwm;
  logic       r_wrap;
  logic       r_seq_err;

  assign w_count = {i_count_7, i_count_6, i_count_5, i_count_4,
                    i_count_3, i_count_2, i_count_1, i_count_0};
  assign w_duty  = {i_duty_7, i_duty_6, i_duty_5, i_duty_4,
                    i_duty_3, i_duty_2, i_duty_1, i_duty_0};

  assign w_prev_inc = r_prev + 8'd1;
  assign w_wrap     = r_prev_valid && (r_prev == 8'hFF) &&
                      (w_count == 8'h00);
  assign w_commit   = w_wrap && r_pend;
  // The committing period must already use the new duty on its first count.
  assign w_eff_duty = w_commit ? r_shadow : r_active;
  assign w_seq_bad  = CHECK_SEQ && r_prev_valid &&
                      (w_count != w_prev_inc);

  // Duty buffering, count history, and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active     <= RESET_DUTY;
      r_shadow     <= RESET_DUTY;
      r_prev       <= 8'd0;
      r_prev_valid <= 1'b0;
      r_pend       <= 1'b0;
      r_pwm        <= 1'b0;
      r_wrap       <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_prev       <= w_count;
      r_prev_valid <= 1'b1;
      if (w_commit) begin
        r_active <= r_shadow;
        r_pend   <= 1'b0;
      end
      // A load in the commit cycle refills the shadow and stays pending.
      if (i_load) begin
        r_shadow <= w_duty;
        r_pend   <= 1'b1;
      end
      r_pwm  <= (w_count < w_eff_duty);
      r_wrap <= w_wrap;
      if (w_seq_bad)
        r_seq_err <= 1'b1;
    end
  end

  assign o_pwm     = r_pwm;
  assign o_wrap    = r_wrap;
  assign o_pending = r_pend;
  assign o_seq_err = r_seq_err;

endmodule

// File: tb/tb_x_pwm_8_bit.sv
// tb_x_pwm_8_bit: directed bench for the 8-bit PWM.
// Each task runs one scenario and checks its own results.
module tb_x_pwm_8_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] count = 8'd0;
  logic [7:0] duty = 8'd0;
  logic       load = 1'b0;
  logic       o_pwm, o_wrap, o_pending, o_seq_err;

  int chk = 0;
  int err = 0;
  int hi, wr, fl;

  always #5 clk = ~clk;

  x_pwm_8_bit #(.RESET_DUTY(8'd0), .CHECK_SEQ(1'b1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_count_7(count[7]), .i_count_6(count[6]),
    .i_count_5(count[5]), .i_count_4(count[4]),
    .i_count_3(count[3]), .i_count_2(count[2]),
    .i_count_1(count[1]), .i_count_0(count[0]),
    .i_duty_7(duty[7]), .i_duty_6(duty[6]),
    .i_duty_5(duty[5]), .i_duty_4(duty[4]),
    .i_duty_3(duty[3]), .i_duty_2(duty[2]),
    .i_duty_1(duty[1]), .i_duty_0(duty[0]),
    .i_load(load),
    .o_pwm(o_pwm), .o_wrap(o_wrap),
    .o_pending(o_pending), .o_seq_err(o_seq_err)
  );

  task automatic step(input logic [7:0] c, input logic ld,
                      input logic [7:0] d, input logic r);
    count = c; load = ld; duty = d; rst = r;
    @(posedge clk);
    #1;
    load = 1'b0; rst = 1'b0;
  endtask

  task automatic period(input int la1, input logic [7:0] d1,
                        input int la2, input logic [7:0] d2,
                        output int highs, output int wraps,
                        output int first_low);
    highs = 0; wraps = 0; first_low = -1;
    for (int i = 0; i < 256; i++) begin
      step(8'(i), (i == la1) || (i == la2),
           (i == la2) ? d2 : d1, 1'b0);
      if (o_pwm) highs++;
      else if (first_low < 0) first_low = i;
      if (o_wrap) wraps++;
    end
  endtask

  task automatic test_reset;
    step(8'h00, 1'b0, 8'h00, 1'b1);
    chk++; if (o_pwm !== 1'b0) begin err++;
      $display("FAIL reset_pwm got %b exp 0", o_pwm); end
    chk++; if (o_wrap !== 1'b0) begin err++;
      $display("FAIL reset_wrap got %b exp 0", o_wrap); end
    chk++; if (o_pending !== 1'b0) begin err++;
      $display("FAIL reset_pend got %b exp 0", o_pending); end
    chk++; if (o_seq_err !== 1'b0) begin err++;
      $display("FAIL reset_seq got %b exp 0", o_seq_err); end
  endtask

  task automatic test_clean;
    period(-1, 8'h00, -1, 8'h00, hi, wr, fl);
    chk++; if (hi !== 0) begin err++;
      $display("FAIL clean1_highs got %0d exp 0", hi); end
    chk++; if (wr !== 0) begin err++;
      $display("FAIL clean1_wraps got %0d exp 0", wr); end
    step(8'h00, 1'b0, 8'h00, 1'b0);
    chk++; if (o_wrap !== 1'b1) begin err++;
      $display("FAIL wrap_pulse got %b exp 1", o_wrap); end
    step(8'h01, 1'b0, 8'h00, 1'b0);
    chk++; if (o_wrap !== 1'b0) begin err++;
      $display("FAIL wrap_one_cycle got %b exp 0", o_wrap); end
    for (int i = 2; i < 256; i++) step(8'(i), 1'b0, 8'h00, 1'b0);
    chk++; if (o_seq_err !== 1'b0) begin err++;
      $display("FAIL clean_seq got %b exp 0", o_seq_err); end
  endtask

  task automatic test_load;
    period(8'h80, 8'h40, -1, 8'h00, hi, wr, fl);
    chk++; if (o_pending !== 1'b1) begin err++;
      $display("FAIL load_pend got %b exp 1", o_pending); end
    chk++; if (hi !== 0) begin err++;
      $display("FAIL load_old_highs got %0d exp 0", hi); end
    period(-1, 8'h00, -1, 8'h00, hi, wr, fl);
    chk++; if (hi !== 64) begin err++;
      $display("FAIL load_highs got %0d exp 64", hi); end
    chk++; if (fl !== 64) begin err++;
      $display("FAIL load_first_low got %0d exp 64", fl); end
    chk++; if (wr !== 1) begin err++;
      $display("FAIL load_wraps got %0d exp 1", wr); end
    chk++; if (o_pending !== 1'b0) begin err++;
      $display("FAIL load_pend_clr got %b exp 0", o_pending); end
  endtask

  task automatic test_overwrite;
    period(8'h20, 8'h10, 8'h30, 8'hC0, hi, wr, fl);
    chk++; if (hi !== 64) begin err++;
      $display("FAIL ovw_old_highs got %0d exp 64", hi); end
    period(-1, 8'h00, -1, 8'h00, hi, wr, fl);
    chk++; if (hi !== 192) begin err++;
      $display("FAIL ovw_highs got %0d exp 192", hi); end
    chk++; if (fl !== 192) begin err++;
      $display("FAIL ovw_first_low got %0d exp 192", fl); end
  endtask

  task automatic test_back_to_back;
    period(8'h50, 8'h20, -1, 8'h00, hi, wr, fl);
    chk++; if (hi !== 192) begin err++;
      $display("FAIL b2b_a_highs got %0d exp 192", hi); end
    period(0, 8'hFF, -1, 8'h00, hi, wr, fl);
    chk++; if (hi !== 32) begin err++;
      $display("FAIL b2b_b_highs got %0d exp 32", hi); end
    chk++; if (o_pending !== 1'b1) begin err++;
      $display("FAIL b2b_b_pend got %b exp 1", o_pending); end
    period(-1, 8'h00, -1, 8'h00, hi, wr, fl);
    chk++; if (hi !== 255) begin err++;
      $display("FAIL b2b_c_highs got %0d exp 255", hi); end
    chk++; if (fl !== 255) begin err++;
      $display("FAIL b2b_c_first_low got %0d exp 255", fl); end
    chk++; if (o_pending !== 1'b0) begin err++;
      $display("FAIL b2b_c_pend got %b exp 0", o_pending); end
  endtask

  task automatic test_seq_err;
    for (int i = 0; i <= 16; i++)
      step(8'(i), i == 5, 8'h80, 1'b0);
    chk++; if (o_seq_err !== 1'b0) begin err++;
      $display("FAIL seq_pre got %b exp 0", o_seq_err); end
    step(8'h20, 1'b0, 8'h00, 1'b0);
    chk++; if (o_seq_err !== 1'b1) begin err++;
      $display("FAIL seq_jump got %b exp 1", o_seq_err); end
    chk++; if (o_wrap !== 1'b0) begin err++;
      $display("FAIL seq_jump_wrap got %b exp 0", o_wrap); end
    chk++; if (o_pending !== 1'b1) begin err++;
      $display("FAIL seq_jump_pend got %b exp 1", o_pending); end
    for (int i = 33; i < 256; i++) step(8'(i), 1'b0, 8'h00, 1'b0);
    period(-1, 8'h00, -1, 8'h00, hi, wr, fl);
    chk++; if (hi !== 128) begin err++;
      $display("FAIL seq_highs got %0d exp 128", hi); end
    chk++; if (wr !== 1) begin err++;
      $display("FAIL seq_wraps got %0d exp 1", wr); end
    chk++; if (o_seq_err !== 1'b1) begin err++;
      $display("FAIL seq_sticky got %b exp 1", o_seq_err); end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i <= 48; i++)
      step(8'(i), i == 48, 8'h99, 1'b0);
    chk++; if (o_pending !== 1'b1) begin err++;
      $display("FAIL mr_pend_pre got %b exp 1", o_pending); end
    step(8'h31, 1'b0, 8'h00, 1'b1);
    chk++; if (o_pwm !== 1'b0) begin err++;
      $display("FAIL mr_pwm got %b exp 0", o_pwm); end
    chk++; if (o_pending !== 1'b0) begin err++;
      $display("FAIL mr_pend got %b exp 0", o_pending); end
    chk++; if (o_seq_err !== 1'b0) begin err++;
      $display("FAIL mr_seq got %b exp 0", o_seq_err); end
    step(8'h62, 1'b0, 8'h00, 1'b0);
    chk++; if (o_seq_err !== 1'b0) begin err++;
      $display("FAIL mr_first_sample got %b exp 0", o_seq_err); end
    for (int i = 99; i < 256; i++) step(8'(i), 1'b0, 8'h00, 1'b0);
    period(-1, 8'h00, -1, 8'h00, hi, wr, fl);
    chk++; if (hi !== 0) begin err++;
      $display("FAIL mr_highs got %0d exp 0", hi); end
    chk++; if (wr !== 1) begin err++;
      $display("FAIL mr_wraps got %0d exp 1", wr); end
    chk++; if (o_pending !== 1'b0) begin err++;
      $display("FAIL mr_pend_post got %b exp 0", o_pending); end
    chk++; if (o_seq_err !== 1'b0) begin err++;
      $display("FAIL mr_seq_post got %b exp 0", o_seq_err); end
  endtask

  task automatic test_stuck;
    step(8'h00, 1'b0, 8'h00, 1'b1);
    step(8'h00, 1'b1, 8'h10, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);
    chk++; if (o_pending !== 1'b1) begin err++;
      $display("FAIL stuck_pend got %b exp 1", o_pending); end
    chk++; if (o_wrap !== 1'b0) begin err++;
      $display("FAIL stuck_wrap got %b exp 0", o_wrap); end
    chk++; if (o_seq_err !== 1'b1) begin err++;
      $display("FAIL stuck_seq got %b exp 1", o_seq_err); end
    chk++; if (o_pwm !== 1'b0) begin err++;
      $display("FAIL stuck_pwm got %b exp 0", o_pwm); end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_load;
    test_overwrite;
    test_back_to_back;
    test_seq_err;
    test_mid_reset;
    test_stuck;
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
